// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for the stopwatch display.
// A prescaler divides the clock into digit slots; each slot starts with a
// short all-anodes-off interval to stop ghosting, then shows one digit.
// All four BCD inputs are snapshotted once per frame so a frame never mixes
// digits from two different counter values.
module seven_seg_scan #(
    parameter int         REFRESH_DIV = 100000,
    parameter int         BLANK_CYC   = 16,
    parameter logic [3:0] DP_MASK     = 4'b1010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int              PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END = PW'(BLANK_CYC);
    localparam logic [PW-1:0]   PRE_ONE   = PW'(1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    state_t        state;
    state_t        state_nxt;
    logic          wrap;
    logic [3:0]    snap [4];

    logic [3:0]    cur_digit;
    logic          digit_blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next scan position: prescaler wraps on equality, slot index steps on the wrap.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no latch can be inferred.
        wrap          = (prescaler == PRE_LAST);
        prescaler_nxt = wrap ? '0 : prescaler + PRE_ONE;
        idx_nxt       = wrap ? idx + 2'd1 : idx;
        state_nxt     = (prescaler_nxt < BLANK_END) ? BLANK : SHOW;
    end

    // Output pattern for the current slot, registered on the next edge.
    always_comb begin
        cur_digit   = snap[idx];
        digit_blank = blank_lz &&
                      (((idx == 2'd3) && (snap[3] == 4'd0)) ||
                       ((idx == 2'd2) && (snap[3] == 4'd0) && (snap[2] == 4'd0)));
        an_nxt      = 4'b1111;
        seg_nxt     = 7'b1111111;
        dp_nxt      = 1'b1;
        if (state == SHOW) begin
            if (en) begin
                an_nxt = ~(4'b0001 << idx);
            end
            seg_nxt = digit_blank ? 7'b1111111 : decode(cur_digit);
            dp_nxt  = digit_blank ? 1'b1 : ~DP_MASK[idx];
        end
    end

    // Scan state machine, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
            idx       <= 2'd0;
            state     <= BLANK;
            // NOTE: the snapshot is cleared on reset so the first frame shows zeros, not stale digits.
            for (int i = 0; i < 4; i++) begin
                snap[i] <= 4'd0;
            end
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register here sample pre-edge values.
            prescaler <= prescaler_nxt;
            idx       <= idx_nxt;
            state     <= state_nxt;
            if (wrap && (idx == 2'd3)) begin
                snap[0] <= d0;
                snap[1] <= d1;
                snap[2] <= d2;
                snap[3] <= d3;
            end
            an        <= an_nxt;
            seg       <= seg_nxt;
            dp        <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with an 8-cycle slot and 2-cycle blank.
// Each frame record sets the inputs for the next snapshot and lists the
// digits expected on the display during that frame.
module tb_seven_seg_scan;

    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;

    localparam logic [6:0] S_0    = 7'b1000000;
    localparam logic [6:0] S_1    = 7'b1111001;
    localparam logic [6:0] S_2    = 7'b0100100;
    localparam logic [6:0] S_3    = 7'b0110000;
    localparam logic [6:0] S_4    = 7'b0011001;
    localparam logic [6:0] S_5    = 7'b0010010;
    localparam logic [6:0] S_7    = 7'b1111000;
    localparam logic [6:0] S_8    = 7'b0000000;
    localparam logic [6:0] S_9    = 7'b0010000;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S_OFF  = 7'b1111111;

    logic       clk;
    logic       reset;
    logic       en;
    logic       blank_lz;
    logic [3:0] d0, d1, d2, d3;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks;
    int n_fail;

    typedef struct {
        string           name;
        logic            blank_lz;
        logic [3:0]      d3, d2, d1, d0;
        logic [3:0][6:0] seg;   // expected per slot, index = slot
        logic [3:0]      dp;    // expected per slot, bit = slot
    } frame_vec_t;

    frame_vec_t vecs [8];

    seven_seg_scan #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .DP_MASK    (4'b1010)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .blank_lz (blank_lz),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run cycles [first..last] of slot s; cycles 0..1 are the blank interval.
    task automatic run_slot(input int s, input int first, input int last,
                            input logic [6:0] seg_e, input logic dp_e, input string tag);
        logic [3:0] an_show;
        an_show = 4'b1111 & ~(4'b0001 << s);
        for (int c = first; c <= last; c++) begin
            step();
            if (c < BLANK_CYC) begin
                check($sformatf("%s s%0d c%0d an", tag, s, c), 32'(an), 32'(4'b1111));
                check($sformatf("%s s%0d c%0d seg", tag, s, c), 32'(seg), 32'(S_OFF));
                check($sformatf("%s s%0d c%0d dp", tag, s, c), 32'(dp), 32'(1'b1));
            end else begin
                check($sformatf("%s s%0d c%0d an", tag, s, c), 32'(an), 32'(an_show));
                check($sformatf("%s s%0d c%0d seg", tag, s, c), 32'(seg), 32'(seg_e));
                check($sformatf("%s s%0d c%0d dp", tag, s, c), 32'(dp), 32'(dp_e));
            end
        end
    endtask

    task automatic apply(input frame_vec_t v);
        blank_lz = v.blank_lz;
        d3 = v.d3;
        d2 = v.d2;
        d1 = v.d1;
        d0 = v.d0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        apply(v);
        for (int s = 0; s < 4; s++) begin
            run_slot(s, 0, REFRESH_DIV - 1, v.seg[s], v.dp[s], v.name);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          name               lz    d3     d2     d1     d0     seg {s3,s2,s1,s0}                dp
        vecs[0] = '{"zero_frame",      1'b0, 4'd9,  4'd5,  4'd3,  4'd7,  {S_0,   S_0,   S_0,    S_0},   4'b0101};
        vecs[1] = '{"decode_9537",     1'b0, 4'd0,  4'd0,  4'd0,  4'd4,  {S_9,   S_5,   S_3,    S_7},   4'b0101};
        vecs[2] = '{"lz_0004",         1'b1, 4'd0,  4'd0,  4'd0,  4'd4,  {S_OFF, S_OFF, S_0,    S_4},   4'b1101};
        vecs[3] = '{"tear_0008",       1'b1, 4'd1,  4'd2,  4'hC,  4'd5,  {S_OFF, S_OFF, S_0,    S_8},   4'b1101};
        vecs[4] = '{"invalid_12C5",    1'b0, 4'd1,  4'd2,  4'hC,  4'd5,  {S_1,   S_2,   S_DASH, S_5},   4'b0101};
        vecs[5] = '{"phase_after_en",  1'b0, 4'd1,  4'd2,  4'hC,  4'd5,  {S_1,   S_2,   S_DASH, S_5},   4'b0101};
        vecs[6] = '{"post_reset_zero", 1'b0, 4'd1,  4'd2,  4'hC,  4'd5,  {S_0,   S_0,   S_0,    S_0},   4'b0101};
        vecs[7] = '{"post_reset_load", 1'b0, 4'd1,  4'd2,  4'hC,  4'd5,  {S_1,   S_2,   S_DASH, S_5},   4'b0101};

        // Reset state
        reset    = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;
        d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset an", 32'(an), 32'(4'b1111));
            check("reset seg", 32'(seg), 32'(S_OFF));
            check("reset dp", 32'(dp), 32'(1'b1));
        end
        reset = 1'b1;

        // Reset scan with zero snapshot, then decode, then leading-zero blanking
        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i]);
        end

        // Tearing: d0 changes during slot 1; this frame keeps showing the old value
        run_slot(0, 0, REFRESH_DIV - 1, vecs[2].seg[0], vecs[2].dp[0], "tear_cur");
        d0 = 4'd8;
        for (int s = 1; s < 4; s++) begin
            run_slot(s, 0, REFRESH_DIV - 1, vecs[2].seg[s], vecs[2].dp[s], "tear_cur");
        end

        // New value appears only after the snapshot; invalid code then shows a dash
        for (int i = 3; i < 5; i++) begin
            run_frame(vecs[i]);
        end

        // Enable dropped for 20 cycles mid-frame; scan keeps its phase
        run_slot(0, 0, REFRESH_DIV - 1, vecs[4].seg[0], vecs[4].dp[0], "en_pre");
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("en_off c%0d an", c), 32'(an), 32'(4'b1111));
        end
        en = 1'b1;
        run_slot(3, 4, REFRESH_DIV - 1, S_1, 1'b0, "en_resume");
        run_frame(vecs[5]);

        // Reset pulse during slot 2 SHOW
        apply(vecs[5]);
        run_slot(0, 0, REFRESH_DIV - 1, vecs[5].seg[0], vecs[5].dp[0], "rst_mid");
        run_slot(1, 0, REFRESH_DIV - 1, vecs[5].seg[1], vecs[5].dp[1], "rst_mid");
        run_slot(2, 0, 3, vecs[5].seg[2], vecs[5].dp[2], "rst_mid");
        reset = 1'b0;
        step();
        check("rst_mid an", 32'(an), 32'(4'b1111));
        check("rst_mid seg", 32'(seg), 32'(S_OFF));
        check("rst_mid dp", 32'(dp), 32'(1'b1));
        reset = 1'b1;
        run_frame(vecs[6]);
        run_frame(vecs[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL take parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 The block SHALL take parameter BLANK_CYC, default 16, meaning cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1 to REFRESH_DIV-1.
REQ-003 The block SHALL take parameter DP_MASK, default 4'b1010, meaning a 1 in bit i lights the decimal point on digit i.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  one clock; reset is synchronous and active-low (reset=0 resets on the next clk rising edge).
REQ-006 en  input  1  display enable; 0 forces all anodes off.
REQ-007 blank_lz  input  1  leading-zero blanking enable for digits 3 and 2.
REQ-008 d0, d1, d2, d3  input  4 each  BCD digits from the stopwatch counter (d0 = tenths, d1 = seconds, d2 = tens of seconds, d3 = minutes).
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 an  output  4  anodes, active-low; an[i] drives digit i, where an[0] is the rightmost digit.

Function
REQ-012 The block SHALL keep a prescaler counting 0 to REFRESH_DIV-1 and wrapping to 0, plus a 2-bit slot index idx that increments modulo 4 on the wrap (0,1,2,3,0).
REQ-013 The state machine SHALL have two states, BLANK and SHOW.
- BLANK holds while prescaler < BLANK_CYC.
- SHOW holds while prescaler is BLANK_CYC to REFRESH_DIV-1.
- The transition SHOW->BLANK coincides with the idx increment.
REQ-014 In BLANK, the outputs SHALL be an=4'b1111, seg=7'b1111111 and dp=1.
REQ-015 In SHOW with en=1, an SHALL be low only in bit idx, seg SHALL decode snap[idx], and dp SHALL be 0 if DP_MASK[idx]=1, else 1.
REQ-016 When en=0, an SHALL be 4'b1111, and the prescaler, idx and snapshot SHALL continue to advance unaffected.
REQ-017 On the cycle the prescaler wraps to 0 with idx going 3->0, the block SHALL latch all four inputs d0..d3 into snap0..snap3, so that one full frame shows a single coherent value (no tearing).
REQ-018 The decode for active-low {g..a} SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- codes 10 to 15 SHALL decode to dash 0111111 (segment g only).
REQ-019 With blank_lz=1:
- digit 3 SHALL be blanked (seg=1111111, dp=1, anode still cycles) when snap3=0.
- digit 2 SHALL be blanked when snap3=0 and snap2=0.
- digits 1 and 0 SHALL never be blanked.
REQ-020 All outputs SHALL be registered, so an, seg and dp change only on a clk rising edge, with one cycle of latency from the prescaler/idx state to the outputs.
REQ-021 The prescaler SHALL be sized to ceil(log2(REFRESH_DIV)) bits, and the compare for the wrap SHALL be equality with REFRESH_DIV-1.

Reset
REQ-022 While reset=0 at a clk edge, the block SHALL apply these values:
- prescaler=0, idx=0, state=BLANK
- snap0..snap3=0
- an=4'b1111, seg=7'b1111111, dp=1
REQ-023 Reset asserted mid-slot SHALL take effect at the next edge regardless of state.
REQ-024 After reset releases, the first slot SHALL be idx=0 with a full BLANK_CYC blank interval, and the snapshot SHALL first be loaded at the end of slot 3.
REQ-025 Changes on d0..d3 SHALL have no effect on the outputs until the next snapshot.

Verification
REQ-026 The bench SHALL run these directed scenarios with REFRESH_DIV=8 and BLANK_CYC=2:
- Reset scan: release reset, en=1 -> an=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2, then 1101, 1011, 0111 in sequence, repeating with a 32-cycle frame.
- Decode: d3..d0=9,5,3,7, blank_lz=0, after the first snapshot -> the slot 0 seg=1111000 (7), slot 1 seg=0110000 (3) with dp=0, slot 2 seg=0010010 (5) with dp=1, slot 3 seg=0010000 (9) with dp=0.
- Leading zero: d3..d0=0,0,0,4, blank_lz=1 -> slots 3 and 2 show seg=1111111 with anode low; slot 1 shows 1000000 with dp=0; slot 0 shows 0011001.
- Tearing: change d0 from 4 to 8 during slot 1 -> slot 0 of the current frame still shows 4, and 8 appears in the frame after the next snapshot.
- Invalid/enable: d1=4'hC -> slot 1 seg=0111111; en=0 for 20 cycles -> an=1111 throughout, and scan phase after en=1 matches an uninterrupted run.
- Reset mid-slot: reset=0 for 1 edge during slot 2 SHOW -> the next output is an=1111, the slot-0 timing restarts, and the snapshot reads 0.
